// File: rtl/serial_add_ctrl.sv
// Bit-serial ripple-add sequencer driving one shared external full adder.
// Latches the sum and shows it in decimal on two active-low 7-segment digits.
module serial_add_ctrl #(
    parameter int WIDTH    = 3,
    parameter int STEP_DIV = 1
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             START_N,
    input  logic [WIDTH-1:0] OP_A,
    input  logic [WIDTH-1:0] OP_B,
    input  logic             CIN,
    output logic             FA_A,
    output logic             FA_B,
    output logic             FA_CIN,
    input  logic             FA_S,
    input  logic             FA_COUT,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH:0]   SUM,
    output logic [6:0]       HEX1_D,
    output logic [6:0]       HEX0_D,
    output logic             HEX1_DP,
    output logic             HEX0_DP
);

    localparam int IW = $clog2(WIDTH + 1);
    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(WIDTH - 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic sync1;
    logic sync2;
    logic sync3;
    logic start_pulse;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [SW-1:0]    step;
    logic [WIDTH:0]   res_q;
    logic [WIDTH:0]   res_nxt;
    logic             step_end;
    logic             last_bit;

    // Two-flop synchronizer plus an edge register; idles high like the key.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= START_N;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign start_pulse = sync3 & ~sync2;

    assign step_end = (step == LAST_STEP);
    assign last_bit = step_end && (idx == LAST_IDX);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        BUSY    = 1'b0;
        DONE    = 1'b0;
        FA_A    = 1'b0;
        FA_B    = 1'b0;
        FA_CIN  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_pulse) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                BUSY    = 1'b1;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                BUSY   = 1'b1;
                FA_A   = a_sh[0];
                FA_B   = b_sh[0];
                FA_CIN = carry;
                if (last_bit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                DONE    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Result with the current FA outputs merged in; the last step adds the carry-out.
    always_comb begin
        res_nxt      = res_q;
        res_nxt[idx] = FA_S;
        if (last_bit) begin
            res_nxt[WIDTH] = FA_COUT;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            step  <= '0;
            res_q <= '0;
            SUM   <= '0;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    a_sh  <= OP_A;
                    b_sh  <= OP_B;
                    carry <= CIN;
                    idx   <= '0;
                    step  <= '0;
                    res_q <= '0;
                end
                S_SHIFT: begin
                    if (step_end) begin
                        res_q <= res_nxt;
                        carry <= FA_COUT;
                        a_sh  <= a_sh >> 1;
                        b_sh  <= b_sh >> 1;
                        idx   <= idx + 1'b1;
                        step  <= '0;
                        if (last_bit) begin
                            SUM <= res_nxt;
                        end
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [6:0] value;
    logic [3:0] tens;
    logic [3:0] ones;

    assign value = 7'(SUM);
    assign tens  = 4'(value / 7'd10);
    assign ones  = 4'(value % 7'd10);

    assign HEX1_D  = seg7(tens);
    assign HEX0_D  = seg7(ones);
    assign HEX1_DP = 1'b1;
    assign HEX0_DP = 1'b1;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with behavioural full adders.
// One instance uses STEP_DIV=1, a second uses STEP_DIV=4.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_n;
    logic       start_div_n;
    logic [2:0] op_a;
    logic [2:0] op_b;
    logic       cin;

    logic       fa_a, fa_b, fa_cin, fa_s, fa_cout;
    logic       busy, done;
    logic [3:0] sum;
    logic [6:0] hex1, hex0;
    logic       dp1, dp0;

    logic       d_fa_a, d_fa_b, d_fa_cin, d_fa_s, d_fa_cout;
    logic       d_busy, d_done;
    logic [3:0] d_sum;
    logic [6:0] d_hex1, d_hex0;
    logic       d_dp1, d_dp0;

    assign fa_s      = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout   = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));
    assign d_fa_s    = d_fa_a ^ d_fa_b ^ d_fa_cin;
    assign d_fa_cout = (d_fa_a & d_fa_b) | (d_fa_cin & (d_fa_a ^ d_fa_b));

    serial_add_ctrl #(.WIDTH(3), .STEP_DIV(1)) u_dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .START_N(start_n),
        .OP_A(op_a), .OP_B(op_b), .CIN(cin),
        .FA_A(fa_a), .FA_B(fa_b), .FA_CIN(fa_cin),
        .FA_S(fa_s), .FA_COUT(fa_cout),
        .BUSY(busy), .DONE(done), .SUM(sum),
        .HEX1_D(hex1), .HEX0_D(hex0),
        .HEX1_DP(dp1), .HEX0_DP(dp0)
    );

    serial_add_ctrl #(.WIDTH(3), .STEP_DIV(4)) u_div (
        .CLOCK_50(clk), .RESET_N(rst_n), .START_N(start_div_n),
        .OP_A(op_a), .OP_B(op_b), .CIN(cin),
        .FA_A(d_fa_a), .FA_B(d_fa_b), .FA_CIN(d_fa_cin),
        .FA_S(d_fa_s), .FA_COUT(d_fa_cout),
        .BUSY(d_busy), .DONE(d_done), .SUM(d_sum),
        .HEX1_D(d_hex1), .HEX0_D(d_hex0),
        .HEX1_DP(d_dp1), .HEX0_DP(d_dp0)
    );

    int checks = 0;
    int errors = 0;

    bit busy_log  [0:63];
    bit done_log  [0:63];
    bit cin_log   [0:63];
    bit d_busy_log[0:63];
    bit d_done_log[0:63];
    bit d_a_log   [0:63];
    bit d_b_log   [0:63];

    function automatic logic [6:0] seg(input int d);
        logic [6:0] s;
        case (d)
            0: s = 7'b1000000;
            1: s = 7'b1111001;
            2: s = 7'b0100100;
            3: s = 7'b0110000;
            4: s = 7'b0011001;
            5: s = 7'b0010010;
            6: s = 7'b0000010;
            7: s = 7'b1111000;
            8: s = 7'b0000000;
            9: s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Press a key for 'hold' cycles, log 'ncyc' cycles, then idle a few cycles.
    task automatic press(input bit use_div, input int hold, input int ncyc);
        if (use_div) start_div_n = 1'b0;
        else start_n = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk); #1;
            busy_log[k]   = busy;
            done_log[k]   = done;
            cin_log[k]    = fa_cin;
            d_busy_log[k] = d_busy;
            d_done_log[k] = d_done;
            d_a_log[k]    = d_fa_a;
            d_b_log[k]    = d_fa_b;
            if (k == hold) begin
                start_n     = 1'b1;
                start_div_n = 1'b1;
            end
        end
        start_n     = 1'b1;
        start_div_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start_n = 1'b1;
        start_div_n = 1'b1;
        op_a = 3'd0;
        op_b = 3'd0;
        cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, sum} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl: busy/done/sum=%b required 000000", {busy, done, sum});
        end
        checks++;
        if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
            errors++;
            $display("FAIL reset_fa: got %b required 000", {fa_a, fa_b, fa_cin});
        end
        checks++;
        if (hex1 !== 7'b1000000 || hex0 !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_hex: got %b %b required 1000000 1000000", hex1, hex0);
        end
        checks++;
        if (dp1 !== 1'b1 || dp0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_dp: got %b%b required 11", dp1, dp0);
        end
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, sum} !== 6'b0 || d_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy/done/sum=%b d_busy=%b required 0", {busy, done, sum}, d_busy);
        end
    endtask

    task automatic test_basic;
        op_a = 3'd5;
        op_b = 3'd3;
        cin = 1'b0;
        press(1'b0, 1, 12);
        for (int k = 1; k <= 12; k++) begin
            checks++;
            if (busy_log[k] !== (k >= 3 && k <= 6)) begin
                errors++;
                $display("FAIL basic_busy k=%0d: got %b required %b", k, busy_log[k], (k >= 3 && k <= 6));
            end
            checks++;
            if (done_log[k] !== (k == 7)) begin
                errors++;
                $display("FAIL basic_done k=%0d: got %b required %b", k, done_log[k], (k == 7));
            end
        end
        checks++;
        if (sum !== 4'b1000) begin
            errors++;
            $display("FAIL basic_sum: got %b required 1000", sum);
        end
        checks++;
        if (hex1 !== 7'b1000000 || hex0 !== 7'b0000000) begin
            errors++;
            $display("FAIL basic_hex: got %b %b required 1000000 0000000", hex1, hex0);
        end
    endtask

    task automatic test_carry;
        op_a = 3'd7;
        op_b = 3'd7;
        cin = 1'b1;
        press(1'b0, 1, 12);
        checks++;
        if (cin_log[3] !== 1'b0) begin
            errors++;
            $display("FAIL carry_load_fa_cin: got %b required 0", cin_log[3]);
        end
        for (int k = 4; k <= 6; k++) begin
            checks++;
            if (cin_log[k] !== 1'b1) begin
                errors++;
                $display("FAIL carry_fa_cin k=%0d: got %b required 1", k, cin_log[k]);
            end
        end
        checks++;
        if (sum !== 4'b1111) begin
            errors++;
            $display("FAIL carry_sum: got %b required 1111", sum);
        end
        checks++;
        if (hex1 !== 7'b1111001 || hex0 !== 7'b0010010) begin
            errors++;
            $display("FAIL carry_hex: got %b %b required 1111001 0010010", hex1, hex0);
        end
    endtask

    task automatic test_hold;
        int n;
        op_a = 3'd1;
        op_b = 3'd2;
        cin = 1'b0;
        press(1'b0, 50, 60);
        n = 0;
        for (int k = 1; k <= 60; k++) n += int'(done_log[k]);
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL hold_one_done: got %0d pulses required 1", n);
        end
        checks++;
        if (sum !== 4'd3) begin
            errors++;
            $display("FAIL hold_sum: got %0d required 3", sum);
        end
    endtask

    task automatic test_ignore;
        int n;
        op_a = 3'd6;
        op_b = 3'd5;
        cin = 1'b0;
        n = 0;
        start_n = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            n += int'(done);
            if (k == 1) start_n = 1'b1;
            if (k == 3) start_n = 1'b0;
            if (k == 4) op_a = 3'd0;
            if (k == 6) start_n = 1'b1;
        end
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL ignore_done_count: got %0d required 1", n);
        end
        checks++;
        if (sum !== 4'd11) begin
            errors++;
            $display("FAIL ignore_sum: got %0d required 11", sum);
        end
        checks++;
        if (hex1 !== 7'b1111001 || hex0 !== 7'b1111001) begin
            errors++;
            $display("FAIL ignore_hex: got %b %b required 1111001 1111001", hex1, hex0);
        end
    endtask

    task automatic test_step_div;
        bit exp_a [0:2];
        bit exp_b [0:2];
        int st;
        int n;
        exp_a = '{1'b0, 1'b1, 1'b0};
        exp_b = '{1'b1, 1'b0, 1'b0};
        op_a = 3'd2;
        op_b = 3'd1;
        cin = 1'b0;
        press(1'b1, 1, 20);
        for (int k = 4; k <= 15; k++) begin
            st = (k - 4) / 4;
            checks++;
            if (d_a_log[k] !== exp_a[st] || d_b_log[k] !== exp_b[st]) begin
                errors++;
                $display("FAIL div_fa_ab k=%0d: got %b%b required %b%b", k, d_a_log[k], d_b_log[k], exp_a[st], exp_b[st]);
            end
        end
        n = 0;
        for (int k = 1; k <= 20; k++) n += int'(d_done_log[k]);
        checks++;
        if (d_done_log[16] !== 1'b1 || n !== 1) begin
            errors++;
            $display("FAIL div_done: at k16 %b count %0d required 1 1", d_done_log[16], n);
        end
        checks++;
        if (d_busy_log[15] !== 1'b1 || d_busy_log[16] !== 1'b0) begin
            errors++;
            $display("FAIL div_busy_edge: got %b%b required 10", d_busy_log[15], d_busy_log[16]);
        end
        checks++;
        if (d_sum !== 4'd3 || d_hex0 !== 7'b0110000 || d_hex1 !== 7'b1000000) begin
            errors++;
            $display("FAIL div_result: sum %0d hex %b %b required 3 1000000 0110000", d_sum, d_hex1, d_hex0);
        end
    endtask

    task automatic test_reset_mid;
        op_a = 3'd6;
        op_b = 3'd6;
        cin = 1'b0;
        start_n = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 1) start_n = 1'b1;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy_before_reset: got %b required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, sum, fa_a, fa_b, fa_cin} !== 9'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b required 0", {busy, done, sum, fa_a, fa_b, fa_cin});
        end
        checks++;
        if (hex1 !== 7'b1000000 || hex0 !== 7'b1000000) begin
            errors++;
            $display("FAIL mid_reset_hex: got %b %b required 1000000 1000000", hex1, hex0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        op_a = 3'd1;
        op_b = 3'd1;
        cin = 1'b1;
        press(1'b0, 1, 12);
        checks++;
        if (sum !== 4'd3 || hex0 !== 7'b0110000) begin
            errors++;
            $display("FAIL mid_next_op: sum %0d hex0 %b required 3 0110000", sum, hex0);
        end
    endtask

    task automatic test_sweep;
        int e;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                for (int c = 0; c < 2; c++) begin
                    op_a = 3'(a);
                    op_b = 3'(b);
                    cin = 1'(c);
                    press(1'b0, 1, 10);
                    e = a + b + c;
                    checks++;
                    if (sum !== 4'(e) || hex1 !== seg(e / 10) || hex0 !== seg(e % 10)) begin
                        errors++;
                        $display("FAIL sweep %0d+%0d+%0d: sum %0d hex %b %b required %0d %b %b",
                                 a, b, c, sum, hex1, hex0, e, seg(e / 10), seg(e % 10));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_carry;
        test_hold;
        test_ignore;
        test_step_div;
        test_reset_mid;
        test_sweep;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer for a single shared 1-bit full adder (FA: A, B, C_in -> S, C_out). It performs a WIDTH-bit ripple addition bit-serially, one FA evaluation per step.
- A push-key starts an operation. The block captures the operands, steps the FA LSB-first while holding the carry in a register, then latches the result and drives two active-low 7-segment digits with its decimal value.
- Sits between the board switches/keys and the FA instance at board top level.

Parameters:
WIDTH, 3, operand width in bits; legal range 1..5 so that the result is at most 99.
STEP_DIV, 1, clock cycles per bit step; must be >= 1. Allows slowing the sequence for on-board viewing.

Ports:
CLOCK_50  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
START_N  in  1  raw active-low start key, asynchronous to CLOCK_50
OP_A  in  WIDTH  operand A
OP_B  in  WIDTH  operand B
CIN  in  1  carry-in
FA_A  out  1  to FA input A
FA_B  out  1  to FA input B
FA_CIN  out  1  to FA carry-in
FA_S  in  1  from FA sum
FA_COUT  in  1  from FA carry-out
BUSY  out  1  high during LOAD and SHIFT
DONE  out  1  one-cycle completion pulse
SUM  out  WIDTH+1  registered result, MSB is carry-out
HEX1_D  out  7  tens digit, active-low segments {g,f,e,d,c,b,a}
HEX0_D  out  7  ones digit, same encoding
HEX1_DP  out  1  constant 1 (dot off)
HEX0_DP  out  1  constant 1 (dot off)

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - state=IDLE; BUSY=0; DONE=0; SUM=0; FA_A=FA_B=FA_CIN=0.
  - Synchronizer flops set to 1; HEX1_D=HEX0_D=7'b1000000 ("00").
  - Reset asserted mid-operation aborts it with no partial result.
- Start detect:
  - START_N passes through a 2-flop synchronizer plus an edge register.
  - start_pulse is high for exactly one cycle on the synchronized 1->0 transition.
  - Holding the key low produces one pulse only.
- Timing reference: cycle 0 is the cycle in which start_pulse is high while in IDLE.
- IDLE:
  - BUSY=0.
  - On start_pulse -> LOAD; otherwise remain in IDLE.
- LOAD (cycle 1):
  - Capture OP_A and OP_B into shift registers; carry register = CIN; bit index = 0; step counter = 0; internal result register cleared.
  - BUSY=1. -> SHIFT.
- SHIFT (cycles 2 .. 1+WIDTH*STEP_DIV):
  - FA_A = a_sh[0], FA_B = b_sh[0], FA_CIN = carry register. These are combinational from the registers and stable for the whole step.
  - Step counter counts 0..STEP_DIV-1. On the final cycle of a step:
    - result[index] = FA_S; carry = FA_COUT.
    - Shift a_sh and b_sh right by 1; index++.
  - On the final cycle of the step with index == WIDTH-1: result[WIDTH] = FA_COUT -> DONE.
- DONE state (cycle 2+WIDTH*STEP_DIV):
  - DONE=1 for exactly this cycle; SUM updates from the result register on the same edge on which DONE rises; BUSY=0.
  - -> IDLE.
- SUM and the HEX outputs hold the last result until the next DONE.
- Ignored events:
  - start_pulse while in LOAD, SHIFT or DONE is ignored and not queued.
  - OP_A, OP_B and CIN changes after LOAD have no effect on the operation in progress.
- FA_A, FA_B and FA_CIN are 0 in every state other than SHIFT.
- Display:
  - HEX digits derive from registered SUM: tens = SUM/10, ones = SUM%10.
  - Encodings: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - The tens digit always shows a value, including 0.

Test Plan:
- WIDTH=3, STEP_DIV=1, behavioural FA; OP_A=5, OP_B=3, CIN=0; pulse START_N -> BUSY high cycles 1-4, DONE only at cycle 5, SUM=4'b1000, HEX1_D=1000000, HEX0_D=0000000.
- OP_A=7, OP_B=7, CIN=1 -> SUM=4'b1111 (15), HEX1_D=1111001, HEX0_D=0010010. Checker confirms FA_CIN sequence 1,1,1 across the three steps.
- START_N held low 50 cycles -> exactly one DONE pulse. A second press during SHIFT, plus OP_A changed to 0 mid-SHIFT -> no extra DONE, result unaffected.
- STEP_DIV=4, OP_A=2, OP_B=1, CIN=0 -> FA_A/FA_B each constant for 4 cycles per step, DONE at cycle 14, SUM=3, HEX0_D=0110000.
- RESET_N pulsed low during SHIFT of a 6+6 operation -> all outputs return to reset values immediately and the display shows "00". Next press with 1+1+1 -> SUM=3.
- Exhaustive sweep over all OP_A, OP_B, CIN for WIDTH=3 -> SUM == OP_A+OP_B+CIN for every case, and HEX digits match the decimal value.
